// File: rtl/ultrasonic_multi.sv
// Round-robin multi-channel ultrasonic ranger (HC-SR04 style sensors).
// One shared FSM triggers each channel in turn, times the echo pulse in
// microseconds and publishes the distance in cm per channel.
module ultrasonic_multi #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int N_CH       = 4,
  parameter int TRIG_US    = 12,
  parameter int TIMEOUT_US = 30_000,
  parameter int GAP_US     = 10_000,
  parameter int DIST_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset_p,
  input  logic                     enable,
  input  logic [N_CH-1:0]          echo,
  output logic [N_CH-1:0]          trig,
  output logic [N_CH*DIST_W-1:0]   distance_cm,
  output logic [N_CH-1:0]          dist_valid,
  output logic [N_CH-1:0]          err,
  output logic                     busy
);

  localparam int DIV_RAW = CLK_HZ / 1_000_000;
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_A   = (GAP_US > TIMEOUT_US) ? GAP_US : TIMEOUT_US;
  localparam int CNT_MAX = (CNT_A > TRIG_US) ? CNT_A : TRIG_US;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  // Quotient width must hold the count, the result and the constant 58.
  localparam int QW_A    = (CNT_W > DIST_W) ? CNT_W : DIST_W;
  localparam int QW      = (QW_A > 7) ? QW_A : 7;

  typedef enum logic [2:0] {IDLE, GAP, TRIG, WAIT_RISE, MEASURE, DONE} state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CH_W-1:0]   ch_q;
  logic [N_CH-1:0]   trig_q;
  logic [N_CH-1:0]   sync1_q;
  logic [N_CH-1:0]   sync2_q;
  logic              sel_prev_q;

  logic              tick;
  logic              sel_s;
  logic              rise;
  logic              fall;
  logic              cnt_to;
  logic              fin_ok;
  logic              fin_to;
  logic [QW-1:0]     quot;
  logic [DIST_W-1:0] dist_sat;

  assign tick = (div_q == DIV_W'(DIV - 1));

  // Free-running microsecond prescaler.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Two-flop synchronisers on every echo pin.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= echo;
      sync2_q <= sync1_q;
    end
  end

  // Pick the synchronised echo of the channel currently being served.
  always_comb begin
    sel_s = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch_q == CH_W'(k)) sel_s = sync2_q[k];
    end
  end

  // sel_prev_q follows the selected echo every cycle, so an echo that is
  // already high when WAIT_RISE starts never looks like a rising edge.
  assign rise   = sel_s & ~sel_prev_q;
  assign fall   = ~sel_s & sel_prev_q;
  assign cnt_to = tick && (cnt_q >= CNT_W'(TIMEOUT_US - 1));
  assign fin_ok = (state_q == MEASURE) && fall;
  assign fin_to = ((state_q == WAIT_RISE) && !rise && cnt_to) ||
                  ((state_q == MEASURE) && !fall && cnt_to);

  assign quot     = QW'(cnt_q) / QW'(58);
  assign dist_sat = (quot > QW'({DIST_W{1'b1}})) ? '1 : quot[DIST_W-1:0];

  // Measurement sequencer: gap, trigger, wait for echo, time echo, publish.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ch_q       <= '0;
      trig_q     <= '0;
      sel_prev_q <= 1'b0;
    end else begin
      sel_prev_q <= sel_s;
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= GAP;
            cnt_q   <= '0;
          end
        end
        GAP: begin
          if (tick) begin
            if (cnt_q >= CNT_W'(GAP_US - 1)) begin
              state_q <= TRIG;
              cnt_q   <= '0;
              trig_q  <= N_CH'(1) << ch_q;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        TRIG: begin
          if (tick) begin
            if (cnt_q >= CNT_W'(TRIG_US - 1)) begin
              state_q <= WAIT_RISE;
              cnt_q   <= '0;
              trig_q  <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        WAIT_RISE: begin
          if (rise) begin
            // The detecting cycle already lies inside the pulse, so its
            // tick is part of the measured width.
            state_q <= MEASURE;
            cnt_q   <= tick ? CNT_W'(1) : '0;
          end else if (fin_to) begin
            state_q <= DONE;
          end else if (tick) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        MEASURE: begin
          if (fin_ok || fin_to) begin
            state_q <= DONE;
          end else if (tick) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          ch_q    <= (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + CH_W'(1);
          cnt_q   <= '0;
          state_q <= enable ? GAP : IDLE;
        end
        default: begin
          state_q <= IDLE;
          trig_q  <= '0;
        end
      endcase
    end
  end

  assign trig = trig_q;
  assign busy = (state_q != IDLE);

  // Per-channel result registers, written on the edge that ends a measurement.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [DIST_W-1:0] dist_q;
      logic              err_q;
      logic              valid_q;
      logic              sel_c;

      assign sel_c = (ch_q == CH_W'(gi));

      // Latch distance/err and pulse valid for this channel.
      always_ff @(posedge clk) begin
        if (reset_p) begin
          dist_q  <= '0;
          err_q   <= 1'b0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= sel_c && (fin_ok || fin_to);
          if (sel_c && fin_ok) begin
            dist_q <= dist_sat;
            err_q  <= 1'b0;
          end else if (sel_c && fin_to) begin
            err_q <= 1'b1;
          end
        end
      end

      assign distance_cm[gi*DIST_W +: DIST_W] = dist_q;
      assign err[gi]                          = err_q;
      assign dist_valid[gi]                   = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_ultrasonic_multi.sv
// Directed bench for ultrasonic_multi: a 2-channel instance with a 1 MHz
// clock (one us tick per cycle) and a 1-channel DIST_W=4 instance.
module tb_ultrasonic_multi;

  localparam int GAP  = 50;
  localparam int TRW  = 12;
  localparam int TO   = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, enable_a, busy_a;
  logic [1:0]  echo_a, trig_a, valid_a, err_a;
  logic [31:0] dist_a;
  logic        reset_b, enable_b, busy_b;
  logic [0:0]  echo_b, trig_b, valid_b, err_b;
  logic [3:0]  dist_b;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  ultrasonic_multi #(
    .CLK_HZ(1_000_000), .N_CH(2), .TRIG_US(TRW), .TIMEOUT_US(TO),
    .GAP_US(GAP), .DIST_W(16)
  ) u_dut (
    .clk(clk), .reset_p(reset_a), .enable(enable_a), .echo(echo_a),
    .trig(trig_a), .distance_cm(dist_a), .dist_valid(valid_a),
    .err(err_a), .busy(busy_a)
  );

  ultrasonic_multi #(
    .CLK_HZ(1_000_000), .N_CH(1), .TRIG_US(TRW), .TIMEOUT_US(TO),
    .GAP_US(GAP), .DIST_W(4)
  ) u_sat (
    .clk(clk), .reset_p(reset_b), .enable(enable_b), .echo(echo_b),
    .trig(trig_b), .distance_cm(dist_b), .dist_valid(valid_b),
    .err(err_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dist_of(input int ch);
    return dist_a[ch*16 +: 16];
  endfunction

  task automatic wait_trig(input int ch, output int rise_cyc);
    rise_cyc = -1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (trig_a[ch] === 1'b1) begin
        rise_cyc = cyc;
        break;
      end
    end
    if (rise_cyc < 0) check("trig_rise_wait", 0, 1);
  endtask

  // Called right after wait_trig: measures trigger width, drives the echo,
  // then waits for the result pulse and checks it lasts one cycle.
  task automatic run_meas(input int ch, input int high_len, input bit stuck,
                          input int drop_at, input int rel_at,
                          output int width, output int fall_cyc, output int valid_cyc);
    width    = 1;
    fall_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (trig_a[ch]) width++;
      else begin
        fall_cyc = cyc;
        break;
      end
    end
    if (fall_cyc < 0) check("trig_fall_wait", 0, 1);
    repeat (5) @(negedge clk);
    if (stuck) echo_a[ch] = 1'b1;
    else if (high_len > 0) begin
      echo_a[ch] = 1'b1;
      for (int i = 0; i < high_len; i++) begin
        if (i == drop_at) enable_a = 1'b0;
        @(negedge clk);
      end
      echo_a[ch] = 1'b0;
    end
    valid_cyc = -1;
    for (int i = 0; i < 3000; i++) begin
      if (i == rel_at) echo_a[ch] = 1'b0;
      if (valid_a[ch]) begin
        valid_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (valid_cyc < 0) check("valid_wait", 0, 1);
    else begin
      @(negedge clk);
      check("valid_one_cycle", 32'(valid_a[ch]), 0);
    end
    $display("meas ch%0d echo=%0d stuck=%0d -> trig_w=%0d dist=%0d err=%0d",
             ch, high_len, stuck, width, dist_of(ch), err_a[ch]);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r, w, f, v, c0, v_prev;
    bit seen;
    reset_a = 1'b1; enable_a = 1'b0; echo_a = '0;
    reset_b = 1'b1; enable_b = 1'b0; echo_b = '0;
    repeat (3) @(negedge clk);
    check("rst_trig", 32'(trig_a), 0);
    check("rst_dist", dist_a, 0);
    check("rst_valid", 32'(valid_a), 0);
    check("rst_err", 32'(err_a), 0);
    check("rst_busy", 32'(busy_a), 0);

    reset_a = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(busy_a), 0);
    check("idle_trig", 32'(trig_a), 0);

    // ch0, 1160 us echo -> 20 cm
    enable_a = 1'b1; c0 = cyc;
    wait_trig(0, r);
    check("first_trig_delay", r - c0, GAP + 1);
    check("trig_onehot_ch0", 32'(trig_a), 32'h1);
    run_meas(0, 1160, 0, -1, -1, w, f, v);
    check("trig_width", w, TRW);
    check("dist0_1160", 32'(dist_of(0)), 20);
    check("err0_ok", 32'(err_a[0]), 0);

    // ch1, 59 us -> 1 cm
    wait_trig(1, r);
    check("trig_onehot_ch1", 32'(trig_a), 32'h2);
    check("gap_after_done", r - v, GAP + 1);
    run_meas(1, 59, 0, -1, -1, w, f, v);
    check("dist1_59", 32'(dist_of(1)), 1);
    check("err1_ok", 32'(err_a[1]), 0);

    // ch0, 57 us -> 0 cm
    wait_trig(0, r);
    run_meas(0, 57, 0, -1, -1, w, f, v);
    check("dist0_57", 32'(dist_of(0)), 0);

    // ch1, no echo -> timeout TO us after trigger falls, distance kept
    wait_trig(1, r);
    run_meas(1, 0, 0, -1, -1, w, f, v);
    check("err1_norise", 32'(err_a[1]), 1);
    check("norise_timeout_time", v - f, TO);
    check("dist1_kept", 32'(dist_of(1)), 1);

    // ch0, 58 us -> 1 cm, err cleared
    wait_trig(0, r);
    run_meas(0, 58, 0, -1, -1, w, f, v);
    check("dist0_58", 32'(dist_of(0)), 1);
    check("err0_58", 32'(err_a[0]), 0);

    // ch1, echo stuck high -> timeout, next channel after the gap
    wait_trig(1, r);
    run_meas(1, 0, 1, -1, -1, w, f, v);
    check("err1_stuck", 32'(err_a[1]), 1);
    check("dist1_stuck_kept", 32'(dist_of(1)), 1);
    v_prev = v;

    // ch0 while echo[1] stays high; enable dropped mid-measurement
    wait_trig(0, r);
    check("gap_after_stuck", r - v_prev, GAP + 1);
    run_meas(0, 200, 0, 100, -1, w, f, v);
    check("dist0_200", 32'(dist_of(0)), 3);
    check("err0_200", 32'(err_a[0]), 0);
    check("busy_after_drop", 32'(busy_a), 0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (trig_a != 2'b00 || busy_a) seen = 1'b1;
    end
    check("stopped_while_disabled", 32'(seen), 0);

    // resume on ch1 with echo already high: no rise, echo drops later
    enable_a = 1'b1; c0 = cyc;
    wait_trig(1, r);
    check("resume_delay", r - c0, GAP + 1);
    check("resume_on_ch1", 32'(trig_a), 32'h2);
    run_meas(1, 0, 0, -1, 300, w, f, v);
    check("err1_prehigh", 32'(err_a[1]), 1);
    check("prehigh_timeout_time", v - f, TO);
    check("dist1_prehigh_kept", 32'(dist_of(1)), 1);

    // ch0 again 1160 us -> 20 cm
    wait_trig(0, r);
    run_meas(0, 1160, 0, -1, -1, w, f, v);
    check("dist0_again", 32'(dist_of(0)), 20);

    // reset in the middle of ch1's trigger pulse
    wait_trig(1, r);
    repeat (4) @(negedge clk);
    reset_a = 1'b1;
    @(negedge clk);
    check("rst_mid_trig", 32'(trig_a), 0);
    check("rst_mid_dist", dist_a, 0);
    check("rst_mid_err", 32'(err_a), 0);
    check("rst_mid_valid", 32'(valid_a), 0);
    check("rst_mid_busy", 32'(busy_a), 0);
    repeat (2) @(negedge clk);
    reset_a = 1'b0; c0 = cyc;
    wait_trig(0, r);
    check("post_rst_delay", r - c0, GAP + 1);
    check("post_rst_ch0", 32'(trig_a), 32'h1);
    $display("reset mid-trig: restart on ch0 after %0d cycles", r - c0);

    // DIST_W=4 instance: 1160 us saturates to 15
    reset_b = 1'b0; enable_b = 1'b1;
    r = -1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (trig_b[0]) begin r = cyc; break; end
    end
    if (r < 0) check("sat_trig_wait", 0, 1);
    f = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!trig_b[0]) begin f = cyc; break; end
    end
    if (f < 0) check("sat_trig_fall_wait", 0, 1);
    repeat (5) @(negedge clk);
    echo_b[0] = 1'b1;
    repeat (1160) @(negedge clk);
    echo_b[0] = 1'b0;
    v = -1;
    for (int i = 0; i < 3000; i++) begin
      if (valid_b[0]) begin v = cyc; break; end
      @(negedge clk);
    end
    if (v < 0) check("sat_valid_wait", 0, 1);
    check("sat_dist", 32'(dist_b), 15);
    check("sat_err", 32'(err_b), 0);
    $display("meas sat ch0 echo=1160 -> dist=%0d err=%0d", dist_b, err_b[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
